psram_xfer_arb: RTL and testbench

- Arbitrates single-transaction access to the PSRAM core between two requesters: the AXI user memory path (usr) and the APB mode-register path (cfg).
- Sits between the AXI slave FSM user port / APB register file and psram_core.
- Serializes requests, tags each issued transfer as memory or config, and returns read data and a completion pulse to the requester that owns it.
- Arbitration is round-robin on contention.

---
 rtl/psram_xfer_arb.sv | 213 +++++++++++++++++++++
 tb/tb_psram_xfer_arb.sv | 476 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/psram_xfer_arb.sv
// Round-robin arbiter serializing usr memory and cfg mode-register transfers into psram_core.
// Optional done-wait timeout with core abort: define PSRAM_ARB_TIMEOUT_EN.
module psram_xfer_arb #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int CNT_WIDTH   = 16,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic                  usr_valid_i,
  output logic                  usr_ready_o,
  input  logic                  usr_wen_i,
  input  logic [ADDR_WIDTH-1:0] usr_addr_i,
  input  logic [DATA_WIDTH-1:0] usr_wdata_i,
  output logic                  usr_rvalid_o,
  output logic [DATA_WIDTH-1:0] usr_rdata_o,
  output logic                  usr_err_o,
  input  logic                  cfg_valid_i,
  output logic                  cfg_ready_o,
  input  logic                  cfg_wen_i,
  input  logic [7:0]            cfg_ma_i,
  input  logic [7:0]            cfg_wdata_i,
  output logic                  cfg_rvalid_o,
  output logic [7:0]            cfg_rdata_o,
  output logic                  cfg_err_o,
  output logic                  xfer_valid_o,
  input  logic                  xfer_ready_i,
  output logic                  xfer_cfg_o,
  output logic                  xfer_wen_o,
  output logic [ADDR_WIDTH-1:0] xfer_addr_o,
  output logic [DATA_WIDTH-1:0] xfer_wdata_o,
  input  logic                  xfer_done_i,
  input  logic [DATA_WIDTH-1:0] xfer_rdata_i,
  output logic                  xfer_abort_o,
  output logic                  busy_o,
  output logic [CNT_WIDTH-1:0]  xfer_cnt_o
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  state_e                state_q, state_d;
  logic                  owner_cfg_q, owner_cfg_d;
  logic                  last_cfg_q, last_cfg_d;
  logic                  wen_q, wen_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] usr_rdata_q, usr_rdata_d;
  logic [7:0]            cfg_rdata_q, cfg_rdata_d;
  logic                  usr_rvalid_q, usr_rvalid_d;
  logic                  cfg_rvalid_q, cfg_rvalid_d;
  logic                  usr_err_q, usr_err_d;
  logic                  cfg_err_q, cfg_err_d;
  logic                  abort_q, abort_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

  logic                  usr_elig, cfg_elig, gnt_usr, gnt_cfg;
  logic                  done_now, timeout;
  logic [DATA_WIDTH-1:0] resp_data;

  if (TIMEOUT_CYC < 2) begin : g_timeout_chk
    $error("psram_xfer_arb: TIMEOUT_CYC must be at least 2");
  end

  // Requests are masked while in reset so the ready pulses stay low with every other output.
  assign usr_elig = usr_valid_i && en_i && !rst_i;
  assign cfg_elig = cfg_valid_i && !rst_i;
  assign gnt_usr  = (state_q == IDLE) && usr_elig && (!cfg_elig || last_cfg_q);
  assign gnt_cfg  = (state_q == IDLE) && cfg_elig && (!usr_elig || !last_cfg_q);

  assign done_now = ((state_q == ISSUE) && xfer_ready_i && xfer_done_i) ||
                    ((state_q == WAIT) && xfer_done_i);

`ifdef PSRAM_ARB_TIMEOUT_EN
  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYC - 1);

  logic [15:0] wait_q, wait_d;

  always_comb begin
    wait_d = wait_q;
    if (state_q == IDLE) begin
      wait_d = '0;
    end else if (state_q == ISSUE || state_q == WAIT) begin
      wait_d = wait_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wait_q <= '0;
    end else begin
      wait_q <= wait_d;
    end
  end

  // A completion landing on the last wait cycle takes priority over the abort.
  assign timeout = (state_q == ISSUE || state_q == WAIT) && (wait_q == WAIT_LAST) && !done_now;
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    owner_cfg_d  = owner_cfg_q;
    last_cfg_d   = last_cfg_q;
    wen_d        = wen_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    usr_rdata_d  = usr_rdata_q;
    cfg_rdata_d  = cfg_rdata_q;
    usr_rvalid_d = 1'b0;
    cfg_rvalid_d = 1'b0;
    usr_err_d    = 1'b0;
    cfg_err_d    = 1'b0;
    abort_d      = 1'b0;
    cnt_d        = cnt_q;
    resp_data    = timeout ? '0 : xfer_rdata_i;
    case (state_q)
      IDLE: begin
        if (gnt_usr) begin
          owner_cfg_d = 1'b0;
          last_cfg_d  = 1'b0;
          wen_d       = usr_wen_i;
          addr_d      = usr_addr_i;
          wdata_d     = usr_wdata_i;
          state_d     = ISSUE;
        end else if (gnt_cfg) begin
          owner_cfg_d = 1'b1;
          last_cfg_d  = 1'b1;
          wen_d       = cfg_wen_i;
          addr_d      = ADDR_WIDTH'(cfg_ma_i);
          wdata_d     = DATA_WIDTH'(cfg_wdata_i);
          state_d     = ISSUE;
        end
      end
      ISSUE, WAIT: begin
        if (done_now || timeout) begin
          state_d = RESP;
          abort_d = timeout;
          if (owner_cfg_q) begin
            cfg_rdata_d  = resp_data[7:0];
            cfg_rvalid_d = 1'b1;
            cfg_err_d    = timeout;
          end else begin
            usr_rdata_d  = resp_data;
            usr_rvalid_d = 1'b1;
            usr_err_d    = timeout;
          end
        end else if (state_q == ISSUE && xfer_ready_i) begin
          state_d = WAIT;
        end
      end
      RESP: begin
        cnt_d   = cnt_q + CNT_WIDTH'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      owner_cfg_q  <= 1'b0;
      last_cfg_q   <= 1'b1;
      wen_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      usr_rdata_q  <= '0;
      cfg_rdata_q  <= '0;
      usr_rvalid_q <= 1'b0;
      cfg_rvalid_q <= 1'b0;
      usr_err_q    <= 1'b0;
      cfg_err_q    <= 1'b0;
      abort_q      <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      owner_cfg_q  <= owner_cfg_d;
      last_cfg_q   <= last_cfg_d;
      wen_q        <= wen_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      usr_rdata_q  <= usr_rdata_d;
      cfg_rdata_q  <= cfg_rdata_d;
      usr_rvalid_q <= usr_rvalid_d;
      cfg_rvalid_q <= cfg_rvalid_d;
      usr_err_q    <= usr_err_d;
      cfg_err_q    <= cfg_err_d;
      abort_q      <= abort_d;
      cnt_q        <= cnt_d;
    end
  end

  assign usr_ready_o  = gnt_usr;
  assign cfg_ready_o  = gnt_cfg;
  assign usr_rvalid_o = usr_rvalid_q;
  assign usr_rdata_o  = usr_rdata_q;
  assign usr_err_o    = usr_err_q;
  assign cfg_rvalid_o = cfg_rvalid_q;
  assign cfg_rdata_o  = cfg_rdata_q;
  assign cfg_err_o    = cfg_err_q;
  assign xfer_valid_o = (state_q == ISSUE);
  assign xfer_cfg_o   = owner_cfg_q;
  assign xfer_wen_o   = wen_q;
  assign xfer_addr_o  = addr_q;
  assign xfer_wdata_o = wdata_q;
  assign xfer_abort_o = abort_q;
  assign busy_o       = (state_q != IDLE);
  assign xfer_cnt_o   = cnt_q;

endmodule

// File: tb/tb_psram_xfer_arb.sv
// Scoreboard bench for psram_xfer_arb: a small core model answers transfers, responses are
// checked against expectations queued when each request is accepted.
module tb_psram_xfer_arb;

`ifdef PSRAM_ARB_TIMEOUT_EN
  localparam int TO_CYC = 8;
`else
  localparam int TO_CYC = 1024;
`endif
  localparam int WAIT_MAX = 200;

  logic        clk, rst_i, en_i;
  logic        usr_valid_i, usr_ready_o, usr_wen_i;
  logic [31:0] usr_addr_i, usr_wdata_i;
  logic        usr_rvalid_o, usr_err_o;
  logic [31:0] usr_rdata_o;
  logic        cfg_valid_i, cfg_ready_o, cfg_wen_i;
  logic [7:0]  cfg_ma_i, cfg_wdata_i;
  logic        cfg_rvalid_o, cfg_err_o;
  logic [7:0]  cfg_rdata_o;
  logic        xfer_valid_o, xfer_ready_i, xfer_cfg_o, xfer_wen_o;
  logic [31:0] xfer_addr_o, xfer_wdata_o, xfer_rdata_i;
  logic        xfer_done_i, xfer_abort_o, busy_o;
  logic [15:0] xfer_cnt_o;

  psram_xfer_arb #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .CNT_WIDTH(16), .TIMEOUT_CYC(TO_CYC)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .en_i(en_i),
    .usr_valid_i(usr_valid_i), .usr_ready_o(usr_ready_o), .usr_wen_i(usr_wen_i),
    .usr_addr_i(usr_addr_i), .usr_wdata_i(usr_wdata_i), .usr_rvalid_o(usr_rvalid_o),
    .usr_rdata_o(usr_rdata_o), .usr_err_o(usr_err_o),
    .cfg_valid_i(cfg_valid_i), .cfg_ready_o(cfg_ready_o), .cfg_wen_i(cfg_wen_i),
    .cfg_ma_i(cfg_ma_i), .cfg_wdata_i(cfg_wdata_i), .cfg_rvalid_o(cfg_rvalid_o),
    .cfg_rdata_o(cfg_rdata_o), .cfg_err_o(cfg_err_o),
    .xfer_valid_o(xfer_valid_o), .xfer_ready_i(xfer_ready_i), .xfer_cfg_o(xfer_cfg_o),
    .xfer_wen_o(xfer_wen_o), .xfer_addr_o(xfer_addr_o), .xfer_wdata_o(xfer_wdata_o),
    .xfer_done_i(xfer_done_i), .xfer_rdata_i(xfer_rdata_i), .xfer_abort_o(xfer_abort_o),
    .busy_o(busy_o), .xfer_cnt_o(xfer_cnt_o)
  );

  typedef struct {
    logic        cfg;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t sbq[$];
  exp_t sb_e;
  logic gnt_log[$];
  logic acc_log[$];
  int   acc_cnt = 0;
  int   checks = 0;
  int   failures = 0;

  int   core_rdy_lat = 0;
  int   core_done_lat = 0;
  bit   core_hang = 0;
  int   core_clr_req = 0;
  logic [31:0] core_addr;

  function automatic logic [31:0] core_fn(input logic [31:0] a);
    return a ^ 32'hDEADBFEF;
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Core model: accepts after core_rdy_lat ISSUE cycles, completes core_done_lat cycles later.
  initial begin : core_model
    int  rdy_wait;
    int  dwait;
    int  clr_seen;
    bit  pend;
    rdy_wait = 0; dwait = 0; clr_seen = 0; pend = 0;
    xfer_ready_i = 1'b0; xfer_done_i = 1'b0; xfer_rdata_i = '0; core_addr = '0;
    forever begin
      @(posedge clk); #1;
      xfer_ready_i = 1'b0;
      xfer_done_i  = 1'b0;
      if (core_clr_req != clr_seen || xfer_abort_o) begin
        clr_seen = core_clr_req; pend = 0; rdy_wait = 0;
      end
      if (xfer_valid_o && !pend) begin
        if (rdy_wait >= core_rdy_lat) begin
          xfer_ready_i = 1'b1; rdy_wait = 0; core_addr = xfer_addr_o;
          if (core_done_lat == 0 && !core_hang) begin
            xfer_done_i = 1'b1; xfer_rdata_i = core_fn(core_addr);
          end else begin
            pend = 1; dwait = 1;
          end
        end else begin
          rdy_wait++;
        end
      end else if (pend && !core_hang) begin
        if (dwait >= core_done_lat) begin
          xfer_done_i = 1'b1; xfer_rdata_i = core_fn(core_addr); pend = 0;
        end else begin
          dwait++;
        end
      end
    end
  end

  // Grant / accept logger.
  initial forever begin
    @(negedge clk);
    if (usr_ready_o || cfg_ready_o) begin
      checks++;
      if (usr_ready_o && cfg_ready_o) begin
        failures++;
        $display("FAIL dual_grant: usr_ready=%0b cfg_ready=%0b, at most one required", usr_ready_o, cfg_ready_o);
      end
    end
    if (usr_ready_o) gnt_log.push_back(1'b0);
    if (cfg_ready_o) gnt_log.push_back(1'b1);
    if (xfer_valid_o && xfer_ready_i) begin
      acc_log.push_back(xfer_cfg_o);
      acc_cnt++;
    end
  end

  // Response scoreboard.
  initial forever begin
    @(negedge clk);
    if (usr_rvalid_o || cfg_rvalid_o) begin
      checks++;
      if (sbq.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected: usr_rvalid=%0b cfg_rvalid=%0b with no pending request", usr_rvalid_o, cfg_rvalid_o);
      end else begin
        sb_e = sbq.pop_front();
        if (sb_e.cfg) begin
          if (!(cfg_rvalid_o === 1'b1 && usr_rvalid_o === 1'b0 && cfg_rdata_o === sb_e.data[7:0] && cfg_err_o === sb_e.err)) begin
            failures++;
            $display("FAIL sb_cfg: got rvalid u/c=%0b/%0b rdata=%h err=%0b, expected cfg rdata=%h err=%0b",
                     usr_rvalid_o, cfg_rvalid_o, cfg_rdata_o, cfg_err_o, sb_e.data[7:0], sb_e.err);
          end
        end else begin
          if (!(usr_rvalid_o === 1'b1 && cfg_rvalid_o === 1'b0 && usr_rdata_o === sb_e.data && usr_err_o === sb_e.err)) begin
            failures++;
            $display("FAIL sb_usr: got rvalid u/c=%0b/%0b rdata=%h err=%0b, expected usr rdata=%h err=%0b",
                     usr_rvalid_o, cfg_rvalid_o, usr_rdata_o, usr_err_o, sb_e.data, sb_e.err);
          end
        end
      end
    end
  end

  // Drivers: start at posedge+1, return at posedge+1 of the cycle after acceptance (cyc=-1 on timeout).
  task automatic usr_send(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input bit push, input bit terr, output int cyc);
    exp_t e;
    usr_wen_i = w; usr_addr_i = a; usr_wdata_i = d; usr_valid_i = 1'b1;
    cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (usr_ready_o) break;
      if (cyc >= WAIT_MAX) begin cyc = -1; break; end
    end
    if (cyc > 0 && push) begin
      e.cfg = 1'b0; e.data = terr ? 32'h0 : core_fn(a); e.err = terr;
      sbq.push_back(e);
    end
    @(posedge clk); #1;
    usr_valid_i = 1'b0;
  endtask

  task automatic cfg_send(input logic w, input logic [7:0] ma, input logic [7:0] d,
                          input bit push, output int cyc);
    exp_t e;
    cfg_wen_i = w; cfg_ma_i = ma; cfg_wdata_i = d; cfg_valid_i = 1'b1;
    cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (cfg_ready_o) break;
      if (cyc >= WAIT_MAX) begin cyc = -1; break; end
    end
    if (cyc > 0 && push) begin
      e.cfg = 1'b1; e.data = core_fn({24'h0, ma}); e.err = 1'b0;
      sbq.push_back(e);
    end
    @(posedge clk); #1;
    cfg_valid_i = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 60 && sbq.size() != 0; i++) @(negedge clk);
    checks++;
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL %s_drain: %0d responses outstanding, expected 0", name, sbq.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; usr_valid_i = 1'b1; cfg_valid_i = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({usr_ready_o, usr_rvalid_o, usr_err_o, cfg_ready_o, cfg_rvalid_o, cfg_err_o,
         xfer_valid_o, xfer_cfg_o, xfer_wen_o, xfer_abort_o, busy_o} !== 11'b0) begin
      failures++;
      $display("FAIL reset_flags: got %b expected 0", {usr_ready_o, usr_rvalid_o, usr_err_o, cfg_ready_o,
               cfg_rvalid_o, cfg_err_o, xfer_valid_o, xfer_cfg_o, xfer_wen_o, xfer_abort_o, busy_o});
    end
    checks++;
    if ({xfer_addr_o, xfer_wdata_o, usr_rdata_o, cfg_rdata_o, xfer_cnt_o} !== 120'b0) begin
      failures++;
      $display("FAIL reset_data: addr=%h wdata=%h urd=%h crd=%h cnt=%0d expected all 0",
               xfer_addr_o, xfer_wdata_o, usr_rdata_o, cfg_rdata_o, xfer_cnt_o);
    end
    @(posedge clk); #1;
    usr_valid_i = 1'b0; cfg_valid_i = 1'b0; rst_i = 1'b0;
    @(negedge clk);
    checks++;
    if (busy_o !== 1'b0 || xfer_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle: busy=%0b xfer_valid=%0b expected 0/0", busy_o, xfer_valid_o);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_basic_read();
    int cyc;
    usr_send(1'b0, 32'h100, 32'h0, 1, 0, cyc);
    checks++;
    if (cyc != 1) begin
      failures++; $display("FAIL basic_ready_cycle: got %0d expected 1", cyc);
    end
    @(negedge clk);
    checks++;
    if (xfer_valid_o !== 1'b1 || xfer_cfg_o !== 1'b0 || xfer_wen_o !== 1'b0 || xfer_addr_o !== 32'h100) begin
      failures++;
      $display("FAIL basic_issue: valid=%0b cfg=%0b wen=%0b addr=%h expected 1/0/0/00000100",
               xfer_valid_o, xfer_cfg_o, xfer_wen_o, xfer_addr_o);
    end
    @(negedge clk);
    checks++;
    if (usr_rvalid_o !== 1'b1 || usr_rdata_o !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL basic_resp: rvalid=%0b rdata=%h expected 1/deadbeef", usr_rvalid_o, usr_rdata_o);
    end
    @(negedge clk);
    checks++;
    if (usr_rvalid_o !== 1'b0 || xfer_cnt_o !== 16'd1 || usr_rdata_o !== 32'hDEADBEEF || busy_o !== 1'b0) begin
      failures++;
      $display("FAIL basic_after: rvalid=%0b cnt=%0d rdata=%h busy=%0b expected 0/1/deadbeef/0",
               usr_rvalid_o, xfer_cnt_o, usr_rdata_o, busy_o);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_round_robin();
    int cu0, cu1, cc0, cc1;
    logic exp_seq [4];
    exp_seq[0] = 1'b0; exp_seq[1] = 1'b1; exp_seq[2] = 1'b0; exp_seq[3] = 1'b1;
    rst_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0;
    gnt_log.delete(); acc_log.delete();
    fork
      begin
        usr_send(1'b0, 32'h10, 32'h0, 1, 0, cu0);
        usr_send(1'b1, 32'h14, 32'h55AA_33CC, 1, 0, cu1);
      end
      begin
        cfg_send(1'b0, 8'h01, 8'h00, 1, cc0);
        cfg_send(1'b1, 8'h02, 8'h7E, 1, cc1);
      end
    join
    drain("rr");
    checks++;
    if (cu0 < 0 || cu1 < 0 || cc0 < 0 || cc1 < 0) begin
      failures++; $display("FAIL rr_timeout: waits %0d %0d %0d %0d, expected all granted", cu0, cu1, cc0, cc1);
    end
    checks++;
    if (gnt_log.size() != 4 || acc_log.size() != 4) begin
      failures++;
      $display("FAIL rr_count: grants=%0d accepts=%0d expected 4/4", gnt_log.size(), acc_log.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (gnt_log[i] !== exp_seq[i] || acc_log[i] !== exp_seq[i]) begin
          failures++;
          $display("FAIL rr_order[%0d]: grant=%0b xfer_cfg=%0b expected %0b", i, gnt_log[i], acc_log[i], exp_seq[i]);
        end
      end
    end
  endtask

  task automatic test_en_block();
    int cc, cu;
    gnt_log.delete();
    en_i = 1'b0;
    fork
      begin
        cfg_send(1'b1, 8'h04, 8'h2B, 1, cc);
        @(negedge clk);
        checks++;
        if (xfer_valid_o !== 1'b1 || xfer_cfg_o !== 1'b1 || xfer_wen_o !== 1'b1 ||
            xfer_addr_o !== 32'h4 || xfer_wdata_o !== 32'h2B) begin
          failures++;
          $display("FAIL en_cfg_issue: valid=%0b cfg=%0b wen=%0b addr=%h wdata=%h expected 1/1/1/4/2b",
                   xfer_valid_o, xfer_cfg_o, xfer_wen_o, xfer_addr_o, xfer_wdata_o);
        end
      end
      begin
        usr_send(1'b1, 32'h500, 32'h1234_5678, 1, 0, cu);
      end
      begin
        repeat (10) @(negedge clk);
        checks++;
        if (gnt_log.size() != 1 || gnt_log[0] !== 1'b1) begin
          failures++;
          $display("FAIL en_block: grants=%0d first=%0b expected only one cfg grant", gnt_log.size(), gnt_log[0]);
        end
        @(posedge clk); #1;
        en_i = 1'b1;
      end
    join
    checks++;
    if (cc != 1 || cu <= 10) begin
      failures++; $display("FAIL en_wait: cfg wait=%0d usr wait=%0d expected 1 and >10", cc, cu);
    end
    drain("en");
  endtask

  task automatic test_stall();
    int cyc, a0;
    core_rdy_lat = 5; core_done_lat = 2;
    a0 = acc_cnt;
    usr_send(1'b1, 32'h200, 32'hCAFE_F00D, 1, 0, cyc);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (xfer_valid_o !== 1'b1 || xfer_ready_i !== 1'b0 || xfer_addr_o !== 32'h200 ||
          xfer_wdata_o !== 32'hCAFE_F00D || xfer_wen_o !== 1'b1 || usr_rvalid_o !== 1'b0) begin
        failures++;
        $display("FAIL stall_hold[%0d]: valid=%0b addr=%h wdata=%h wen=%0b rvalid=%0b expected 1/200/cafef00d/1/0",
                 i, xfer_valid_o, xfer_addr_o, xfer_wdata_o, xfer_wen_o, usr_rvalid_o);
      end
    end
    @(negedge clk);
    checks++;
    if (xfer_valid_o !== 1'b1 || xfer_ready_i !== 1'b1) begin
      failures++; $display("FAIL stall_accept: valid=%0b ready=%0b expected 1/1", xfer_valid_o, xfer_ready_i);
    end
    @(negedge clk);
    checks++;
    if (xfer_valid_o !== 1'b0 || busy_o !== 1'b1 || usr_rvalid_o !== 1'b0) begin
      failures++;
      $display("FAIL stall_wait1: valid=%0b busy=%0b rvalid=%0b expected 0/1/0", xfer_valid_o, busy_o, usr_rvalid_o);
    end
    @(negedge clk);
    checks++;
    if (usr_rvalid_o !== 1'b0) begin
      failures++; $display("FAIL stall_wait2: rvalid=%0b expected 0", usr_rvalid_o);
    end
    @(negedge clk);
    checks++;
    if (usr_rvalid_o !== 1'b1) begin
      failures++; $display("FAIL stall_resp: rvalid=%0b expected 1", usr_rvalid_o);
    end
    @(negedge clk);
    checks++;
    if (acc_cnt != a0 + 1) begin
      failures++; $display("FAIL stall_accepts: got %0d expected %0d", acc_cnt - a0, 1);
    end
    core_rdy_lat = 0; core_done_lat = 0;
    drain("stall");
  endtask

  task automatic test_reset_mid();
    int cyc;
    core_hang = 1;
    usr_send(1'b0, 32'h300, 32'h0, 0, 0, cyc);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (busy_o !== 1'b1 || xfer_valid_o !== 1'b0) begin
      failures++; $display("FAIL midrst_wait: busy=%0b valid=%0b expected 1/0", busy_o, xfer_valid_o);
    end
    @(posedge clk); #1;
    rst_i = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy_o, xfer_valid_o, usr_rvalid_o, cfg_rvalid_o, xfer_abort_o, usr_ready_o} !== 6'b0 ||
        xfer_cnt_o !== 16'd0 || xfer_addr_o !== 32'h0 || usr_rdata_o !== 32'h0) begin
      failures++;
      $display("FAIL midrst_zero: busy=%0b valid=%0b rvalid=%0b abort=%0b cnt=%0d addr=%h rdata=%h expected all 0",
               busy_o, xfer_valid_o, usr_rvalid_o, xfer_abort_o, xfer_cnt_o, xfer_addr_o, usr_rdata_o);
    end
    @(posedge clk); #1;
    rst_i = 1'b0; core_hang = 0; core_clr_req++;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (usr_rvalid_o !== 1'b0 || cfg_rvalid_o !== 1'b0 || busy_o !== 1'b0) begin
        failures++;
        $display("FAIL midrst_quiet[%0d]: rvalid u/c=%0b/%0b busy=%0b expected 0", i, usr_rvalid_o, cfg_rvalid_o, busy_o);
      end
    end
    @(posedge clk); #1;
    usr_send(1'b0, 32'h104, 32'h0, 1, 0, cyc);
    checks++;
    if (cyc != 1) begin
      failures++; $display("FAIL midrst_regrant: got wait %0d expected 1", cyc);
    end
    for (int i = 0; i < 20 && sbq.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    checks++;
    if (xfer_cnt_o !== 16'd1 || sbq.size() != 0) begin
      failures++;
      $display("FAIL midrst_after: cnt=%0d pending=%0d expected 1/0", xfer_cnt_o, sbq.size());
    end
    @(posedge clk); #1;
  endtask

`ifdef PSRAM_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int cyc, n;
    core_hang = 1;
    usr_send(1'b0, 32'h400, 32'h0, 1, 1, cyc);
    n = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (xfer_abort_o) begin n = i; break; end
    end
    checks++;
    if (n != TO_CYC) begin
      failures++; $display("FAIL to_abort_cycle: got %0d expected %0d", n, TO_CYC);
    end
    checks++;
    if (usr_rvalid_o !== 1'b1 || usr_err_o !== 1'b1 || usr_rdata_o !== 32'h0) begin
      failures++;
      $display("FAIL to_resp: rvalid=%0b err=%0b rdata=%h expected 1/1/0", usr_rvalid_o, usr_err_o, usr_rdata_o);
    end
    @(negedge clk);
    checks++;
    if (xfer_abort_o !== 1'b0 || busy_o !== 1'b0 || usr_err_o !== 1'b0) begin
      failures++;
      $display("FAIL to_after: abort=%0b busy=%0b err=%0b expected 0/0/0", xfer_abort_o, busy_o, usr_err_o);
    end
    core_hang = 0; core_clr_req++;
    drain("to");
  endtask
`endif

  initial begin
    rst_i = 1'b1; en_i = 1'b1;
    usr_valid_i = 1'b0; usr_wen_i = 1'b0; usr_addr_i = '0; usr_wdata_i = '0;
    cfg_valid_i = 1'b0; cfg_wen_i = 1'b0; cfg_ma_i = '0; cfg_wdata_i = '0;
    @(posedge clk); #1;
    test_reset();
    test_basic_read();
    test_round_robin();
    test_en_block();
    test_stall();
    test_reset_mid();
`ifdef PSRAM_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
